// File: rtl/seq_multiplier_n_pkg.sv
// Shared types and defaults for the iterative shift-add multiplier.
package seq_multiplier_n_pkg;

   localparam int unsigned DEF_N = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_multiplier_n_if.sv
// Operand/product handshake bundle between a requester and the multiplier.
interface seq_multiplier_n_if
   import seq_multiplier_n_pkg::*;
#(
   parameter int unsigned N = DEF_N
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           is_signed;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/adder_n.sv
// N-bit ripple-carry adder used for the partial-sum accumulation.
module adder_n #(
   parameter int unsigned n = 8
) (
   input  logic [n-1:0] i_a,
   input  logic [n-1:0] i_b,
   input  logic         i_cin,
   output logic [n-1:0] o_sum,
   output logic         o_cout
);
   logic [n:0] w_c;

   always_comb begin
      w_c    = '0;
      o_sum  = '0;
      w_c[0] = i_cin;
      for (int i = 0; i < int'(n); i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
      o_cout = w_c[n];
   end
endmodule

// File: rtl/seq_multiplier_n.sv
// Iterative shift-add multiplier: N x N -> 2N, signed or unsigned per operation,
// one operation in flight, valid/ready on both sides.
module seq_multiplier_n
   import seq_multiplier_n_pkg::*;
#(
   parameter int unsigned N = DEF_N
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_multiplier_n_if.slave bus
);
   localparam int unsigned W2 = 2 * N;
   localparam int unsigned CW = $clog2(N + 1);

   state_t          r_state;
   logic [N-1:0]    r_mcand;
   logic [N-1:0]    r_acc_hi;
   logic [N-1:0]    r_mq;
   logic            r_neg;
   logic [CW-1:0]   r_count;
   logic [W2-1:0]   r_product;
   logic            r_in_ready;
   logic            r_out_valid;

   logic [N-1:0]    w_abs_a;
   logic [N-1:0]    w_abs_b;
   logic [N-1:0]    w_addend;
   logic [N-1:0]    w_sum;
   logic            w_cout;
   logic [W2-1:0]   w_mag;

   // Magnitudes at accept; -2^(N-1) maps to 2^(N-1), which still fits N unsigned bits.
   always_comb begin
      w_abs_a = bus.a;
      w_abs_b = bus.b;
      if (bus.is_signed && bus.a[N-1]) w_abs_a = N'(~bus.a + N'(1));
      if (bus.is_signed && bus.b[N-1]) w_abs_b = N'(~bus.b + N'(1));
   end

   assign w_addend = r_mq[0] ? r_mcand : '0;
   assign w_mag    = {r_acc_hi, r_mq};

   adder_n #(.n(N)) u_add (
      .i_a    (r_acc_hi),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Control and datapath; RUN shifts N times, then spends one cycle handing off to FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mcand     <= '0;
         r_acc_hi    <= '0;
         r_mq        <= '0;
         r_neg       <= 1'b0;
         r_count     <= '0;
         r_product   <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_mcand    <= w_abs_a;
                  r_mq       <= w_abs_b;
                  r_acc_hi   <= '0;
                  r_count    <= '0;
                  r_neg      <= bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_count == CW'(N)) begin
                  r_state <= S_FIX;
               end else begin
                  r_acc_hi <= {w_cout, w_sum[N-1:1]};
                  r_mq     <= {w_sum[0], r_mq[N-1:1]};
                  r_count  <= r_count + CW'(1);
               end
            end
            S_FIX: begin
               r_product   <= r_neg ? W2'(~w_mag + W2'(1)) : w_mag;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.product   = r_product;
endmodule

// File: tb/tb_seq_multiplier_n.sv
// Self-checking bench: directed table (N=8), handshake/reset sequences, exhaustive N=4, random N=8/16.
module tb_seq_multiplier_n;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   seq_multiplier_n_if #(.N(4))  b4  ();
   seq_multiplier_n_if #(.N(8))  b8  ();
   seq_multiplier_n_if #(.N(16)) b16 ();

   seq_multiplier_n #(.N(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
   seq_multiplier_n #(.N(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   seq_multiplier_n #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Two's-complement product from plain integer arithmetic, truncated to 2w bits.
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
      longint av, bv, mask;
      mask = (longint'(1) << w) - 1;
      av = longint'(a) & mask;
      bv = longint'(b) & mask;
      if (s && a[w-1]) av = av - (longint'(1) << w);
      if (s && b[w-1]) bv = bv - (longint'(1) << w);
      return 32'((av * bv) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
      case (w)
         4:  begin b4.in_valid  = v; b4.a  = a[3:0]; b4.b  = b[3:0]; b4.is_signed  = s; end
         8:  begin b8.in_valid  = v; b8.a  = a[7:0]; b8.b  = b[7:0]; b8.is_signed  = s; end
         default: begin b16.in_valid = v; b16.a = a; b16.b = b; b16.is_signed = s; end
      endcase
   endtask

   task automatic set_ordy(input logic v);
      b4.out_ready = v; b8.out_ready = v; b16.out_ready = v;
   endtask

   function automatic logic get_ir(input int w);
      return (w == 4) ? b4.in_ready : (w == 8) ? b8.in_ready : b16.in_ready;
   endfunction

   function automatic logic get_ov(input int w);
      return (w == 4) ? b4.out_valid : (w == 8) ? b8.out_valid : b16.out_valid;
   endfunction

   function automatic logic [31:0] get_prod(input int w);
      return (w == 4) ? 32'(b4.product) : (w == 8) ? 32'(b8.product) : 32'(b16.product);
   endfunction

   // Called #1 after an edge; accepts one op, checks latency and product, optionally drains it.
   task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] exp, input string tag, input bit drain);
      int cyc;
      cyc = 0;
      while (!get_ir(w) && cyc < 50) begin @(posedge clk); #1; cyc++; end
      chk({tag, " in_ready"}, 32'(get_ir(w)), 32'd1);
      set_in(w, 1'b1, a, b, s);
      @(posedge clk); #1;
      set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
      cyc = 0;
      while (!get_ov(w) && cyc < 64) begin @(posedge clk); #1; cyc++; end
      chk({tag, " latency"}, 32'(cyc), 32'(w + 2));
      chk({tag, " product"}, get_prod(w), exp);
      if (drain) begin
         set_ordy(1'b1);
         @(posedge clk); #1;
         set_ordy(1'b0);
         chk({tag, " idle out_valid"}, 32'(get_ov(w)), 32'd0);
      end
   endtask

   vec_t         vecs[8];
   logic [15:0]  ra, rb;
   logic         rs;
   logic [31:0]  held;

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set_in(4, 1'b0, 16'h0, 16'h0, 1'b0);
      set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
      set_in(16, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ordy(1'b0);

      vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vecs[3] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
      vecs[4] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
      vecs[5] = '{8'h00, 8'hAB, 1'b1, 16'h0000};
      vecs[6] = '{8'h01, 8'hAB, 1'b1, 16'hFFAB};
      vecs[7] = '{8'h01, 8'hAB, 1'b0, 16'h00AB};

      #12;
      chk("reset in_ready", 32'(b8.in_ready), 32'd1);
      chk("reset out_valid", 32'(b8.out_valid), 32'd0);
      chk("reset product", 32'(b8.product), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i])
         do_op(8, 16'(vecs[i].a), 16'(vecs[i].b), vecs[i].s, 32'(vecs[i].exp),
               $sformatf("vec%0d", i), 1'b1);

      // Stall in DONE: product held, new requests refused, then release.
      do_op(8, 16'h0007, 16'h00F9, 1'b1, 32'h0000FFCF, "stall", 1'b0);
      held = 32'h0000FFCF;
      for (int c = 0; c < 5; c++) begin
         set_in(8, 1'b1, 16'h0003, 16'h0003, 1'b0);
         @(posedge clk); #1;
         chk($sformatf("stall%0d product", c), get_prod(8), held);
         chk($sformatf("stall%0d in_ready", c), 32'(b8.in_ready), 32'd0);
         chk($sformatf("stall%0d out_valid", c), 32'(b8.out_valid), 32'd1);
      end
      set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ordy(1'b1);
      @(posedge clk); #1;
      set_ordy(1'b0);
      chk("release in_ready", 32'(b8.in_ready), 32'd1);
      chk("release out_valid", 32'(b8.out_valid), 32'd0);
      chk("release product kept", get_prod(8), held);
      do_op(8, 16'h000C, 16'h000D, 1'b0, 32'd156, "after_stall", 1'b1);

      // Reset during RUN aborts with cleared outputs.
      set_in(8, 1'b1, 16'h0055, 16'h0033, 1'b0);
      @(posedge clk); #1;
      set_in(8, 1'b0, 16'h0, 16'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort out_valid", 32'(b8.out_valid), 32'd0);
      chk("abort product", 32'(b8.product), 32'd0);
      chk("abort in_ready", 32'(b8.in_ready), 32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort no output", 32'(b8.out_valid), 32'd0);

      for (int s = 0; s < 2; s++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               do_op(4, 16'(x), 16'(y), s[0], ref_mul(4, 16'(x), 16'(y), s[0]),
                     $sformatf("n4 %0d*%0d s%0d", x, y, s), 1'b1);

      for (int k = 0; k < 150; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         do_op(8, ra, rb, rs, ref_mul(8, ra, rb, rs), $sformatf("n8 %h*%h s%0d", ra[7:0], rb[7:0], rs), 1'b1);
      end

      for (int k = 0; k < 100; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         if (k == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
         do_op(16, ra, rb, rs, ref_mul(16, ra, rb, rs), $sformatf("n16 %h*%h s%0d", ra, rb, rs), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
